mux_scan_sequencer: RTL and testbench

Control stage that drives the select and enable inputs of the 16:1 data multiplexer and consumes its output. It sweeps the unmasked channels in ascending order, waits a programmable settle time on each, and captures the selected word into a 16-entry snapshot array. It also tracks per-channel change flags and supports single-sweep and continuous modes. The block lets the CPU datapath or the debug display read any channel's latest value without driving the mux select directly.

---
 rtl/mux_scan_sequencer_pkg.sv | 12 +
 rtl/mux_scan_sequencer_if.sv | 14 +
 rtl/mux_scan_sequencer_mask_next_channel.sv | 25 ++
 rtl/mux_scan_sequencer.sv | 120 ++++++++++++
 tb/tb_mux_scan_sequencer.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/mux_scan_sequencer_pkg.sv
// Shared constants for the mux scan sequencer: state encoding and channel count.
// Constants only; no timing or flow control.
package mux_scan_sequencer_pkg;

  localparam int NrOfChannels = 16;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SETTLE  = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] FINISH  = 2'd3;

endpackage

// File: rtl/mux_scan_sequencer_if.sv
// Select/enable/data bus between the scan sequencer (master) and the 16:1 mux (slave).
// Plain wires; no handshake, the sequencer owns all timing.
interface mux_scan_sequencer_if #(
  parameter int NrOfBits = 32
) ();

  logic [3:0]          MuxSel;
  logic                MuxEnable;
  logic [NrOfBits-1:0] MuxData;

  modport master (output MuxSel, output MuxEnable, input MuxData);
  modport slave  (input MuxSel, input MuxEnable, output MuxData);

endinterface

// File: rtl/mux_scan_sequencer_mask_next_channel.sv
// Finds the lowest set mask bit, either overall or strictly above CurIdx.
// Purely combinational, zero latency; no backpressure.
module mask_next_channel
  import mux_scan_sequencer_pkg::*;
(
  input  logic [NrOfChannels-1:0] Mask,
  input  logic [3:0]              CurIdx,
  input  logic                    FromStart,
  output logic [3:0]              NextIdx,
  output logic                    NextVld
);

  // Scan downward so the last hit written is the lowest qualifying index.
  always_comb begin
    NextIdx = '0;
    NextVld = 1'b0;
    for (int i = NrOfChannels - 1; i >= 0; i--) begin
      if (Mask[i] && (FromStart || (5'(i) > {1'b0, CurIdx}))) begin
        NextIdx = 4'(i);
        NextVld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Sweeps unmasked mux channels, settles SettleCycles then captures each into a snapshot array.
// Per channel SettleCycles+1 cycles, Done one cycle after the last capture; Start ignored while Busy.
module mux_scan_sequencer
  import mux_scan_sequencer_pkg::*;
#(
  parameter int NrOfBits     = 32,
  parameter int SettleCycles = 1
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    Start,
  input  logic                    Continuous,
  input  logic [NrOfChannels-1:0] ChanMask,
  mux_scan_sequencer_if.master    muxBus,
  input  logic [3:0]              RdAddr,
  output logic [NrOfBits-1:0]     RdData,
  output logic [NrOfChannels-1:0] ChangeFlags,
  output logic                    Busy,
  output logic                    Done,
  output logic [7:0]              SweepCount
);

  localparam logic [3:0] SettleLast = 4'(SettleCycles - 1);

  logic [1:0]              state;
  logic [3:0]              ch;
  logic [3:0]              settleCnt;
  logic [NrOfChannels-1:0] maskReg;
  logic [NrOfBits-1:0]     snap [NrOfChannels];

  logic                    fromStart;
  logic [NrOfChannels-1:0] scanMask;
  logic [3:0]              nextIdx;
  logic                    nextVld;

  // Sweep starts look at the live ChanMask; advances look at the latched copy.
  assign fromStart = (state != CAPTURE);
  assign scanMask  = fromStart ? ChanMask : maskReg;

  mask_next_channel uNextChannel (
    .Mask      (scanMask),
    .CurIdx    (ch),
    .FromStart (fromStart),
    .NextIdx   (nextIdx),
    .NextVld   (nextVld)
  );

  assign muxBus.MuxSel    = ch;
  assign muxBus.MuxEnable = (state == SETTLE) || (state == CAPTURE);
  assign Busy             = (state != IDLE);
  assign Done             = (state == FINISH);
  assign RdData           = snap[RdAddr];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= IDLE;
      ch          <= '0;
      settleCnt   <= '0;
      maskReg     <= '0;
      ChangeFlags <= '0;
      SweepCount  <= '0;
      for (int i = 0; i < NrOfChannels; i++) begin
        snap[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            maskReg     <= ChanMask;
            ChangeFlags <= '0;
            settleCnt   <= '0;
            if (nextVld) begin
              ch    <= nextIdx;
              state <= SETTLE;
            end else begin
              state <= FINISH;
            end
          end
        end
        SETTLE: begin
          if (settleCnt == SettleLast) begin
            state <= CAPTURE;
          end else begin
            settleCnt <= settleCnt + 4'd1;
          end
        end
        CAPTURE: begin
          snap[ch] <= muxBus.MuxData;
          if (muxBus.MuxData != snap[ch]) begin
            ChangeFlags[ch] <= 1'b1;
          end
          settleCnt <= '0;
          if (nextVld) begin
            ch    <= nextIdx;
            state <= SETTLE;
          end else begin
            state <= FINISH;
          end
        end
        default: begin
          SweepCount <= SweepCount + 8'd1;
          // A continuous restart keeps the change history of the previous sweep.
          if (Continuous) begin
            maskReg   <= ChanMask;
            settleCnt <= '0;
            if (nextVld) begin
              ch    <= nextIdx;
              state <= SETTLE;
            end else begin
              state <= FINISH;
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer: mux model returns dataBase + MuxSel.
module tb_mux_scan_sequencer;

  localparam int NrOfBits     = 32;
  localparam int SettleCycles = 1;

  logic                Clock      = 1'b0;
  logic                Reset      = 1'b1;
  logic                Start      = 1'b0;
  logic                Continuous = 1'b0;
  logic [15:0]         ChanMask   = 16'h0;
  logic [3:0]          RdAddr     = 4'h0;
  logic [NrOfBits-1:0] RdData;
  logic [15:0]         ChangeFlags;
  logic                Busy;
  logic                Done;
  logic [7:0]          SweepCount;
  logic [31:0]         dataBase   = 32'h0;

  int errors = 0;
  int checks = 0;
  int visits[$];
  int n;

  mux_scan_sequencer_if #(.NrOfBits(NrOfBits)) bus ();

  assign bus.MuxData = dataBase + {28'd0, bus.MuxSel};

  mux_scan_sequencer #(
    .NrOfBits     (NrOfBits),
    .SettleCycles (SettleCycles)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Start       (Start),
    .Continuous  (Continuous),
    .ChanMask    (ChanMask),
    .muxBus      (bus.master),
    .RdAddr      (RdAddr),
    .RdData      (RdData),
    .ChangeFlags (ChangeFlags),
    .Busy        (Busy),
    .Done        (Done),
    .SweepCount  (SweepCount)
  );

  always #5 Clock = ~Clock;

  always @(negedge Clock) begin
    if (!Reset && bus.MuxEnable) visits.push_back(int'(bus.MuxSel));
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic waitDone(output int cnt);
    cnt = 1;
    while (!Done && cnt < 500) begin
      tick();
      cnt++;
    end
  endtask

  task automatic readCheck(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    RdAddr = addr;
    #1;
    check(tag, RdData, exp);
  endtask

  // Expected visit order: each set mask bit, ascending, held SettleCycles+1 cycles.
  task automatic checkOrder(input string tag, input logic [15:0] m);
    int expq[$];
    int mism;
    mism = 0;
    for (int c = 0; c < 16; c++)
      if (m[c])
        for (int r = 0; r <= SettleCycles; r++) expq.push_back(c);
    check({tag, "_len"}, visits.size(), expq.size());
    for (int k = 0; k < expq.size() && k < visits.size(); k++)
      if (visits[k] != expq[k]) mism++;
    check({tag, "_mism"}, mism, 0);
  endtask

  task automatic startSweep(input logic [15:0] m);
    visits.delete();
    ChanMask = m;
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    tick(); tick(); tick();
    check("rst_sel", bus.MuxSel, 0);
    check("rst_en", bus.MuxEnable, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_cnt", SweepCount, 0);
    check("rst_flags", ChangeFlags, 0);
    readCheck("rst_rd7", 4'd7, 0);
    Reset = 1'b0;
    tick();

    // 1: full sweep, 16*2+1 cycles
    dataBase = 32'hA0;
    startSweep(16'hFFFF);
    check("t1_busy", Busy, 1);
    waitDone(n);
    check("t1_len", n, 33);
    checkOrder("t1_order", 16'hFFFF);
    tick();
    check("t1_done_off", Done, 0);
    check("t1_idle", Busy, 0);
    check("t1_cnt", SweepCount, 1);
    check("t1_flags", ChangeFlags, 16'hFFFF);
    readCheck("t1_rd5", 4'd5, 32'hA5);
    readCheck("t1_rd15", 4'd15, 32'hAF);

    // 2: sparse mask, unmasked entries untouched
    dataBase = 32'hB0;
    startSweep(16'h8421);
    waitDone(n);
    check("t2_len", n, 9);
    checkOrder("t2_order", 16'h8421);
    tick();
    check("t2_cnt", SweepCount, 2);
    check("t2_flags", ChangeFlags, 16'h8421);
    readCheck("t2_rd5", 4'd5, 32'hB5);
    readCheck("t2_rd1", 4'd1, 32'hA1);
    readCheck("t2_rd14", 4'd14, 32'hAE);

    // 3: empty mask goes straight to FINISH
    startSweep(16'h0000);
    check("t3_done", Done, 1);
    tick();
    check("t3_noen", visits.size(), 0);
    check("t3_cnt", SweepCount, 3);
    check("t3_flags", ChangeFlags, 0);

    // 4: continuous, back-to-back sweeps, flags persist across restart
    Continuous = 1'b1;
    startSweep(16'h0003);
    waitDone(n);
    check("t4_len1", n, 5);
    tick();
    check("t4_nogap_busy", Busy, 1);
    check("t4_nogap_en", bus.MuxEnable, 1);
    check("t4_nogap_sel", bus.MuxSel, 0);
    Continuous = 1'b0;
    waitDone(n);
    check("t4_len2", n, 5);
    tick();
    check("t4_idle", Busy, 0);
    check("t4_cnt", SweepCount, 5);
    check("t4_flags", ChangeFlags, 16'h0002);
    check("t4_visits", visits.size(), 8);

    // 5: Start and ChanMask activity while Busy is ignored
    dataBase = 32'hC0;
    startSweep(16'h0110);
    Start = 1'b1;
    n = 1;
    while (!Done && n < 500) begin
      Start = (n < 4);
      ChanMask = ~ChanMask;
      tick();
      n++;
    end
    Start = 1'b0;
    check("t5_len", n, 5);
    checkOrder("t5_order", 16'h0110);
    tick();
    tick();
    check("t5_idle", Busy, 0);
    check("t5_cnt", SweepCount, 6);
    check("t5_flags", ChangeFlags, 16'h0110);

    // 6: reset during SETTLE of channel 3
    startSweep(16'hFFFF);
    n = 0;
    while (!(bus.MuxEnable && bus.MuxSel == 4'd3) && n < 500) begin
      tick();
      n++;
    end
    check("t6_at_ch3", n, 6);
    Reset = 1'b1;
    tick();
    check("t6_sel", bus.MuxSel, 0);
    check("t6_en", bus.MuxEnable, 0);
    check("t6_busy", Busy, 0);
    check("t6_done", Done, 0);
    check("t6_cnt", SweepCount, 0);
    check("t6_flags", ChangeFlags, 0);
    for (int a = 0; a < 16; a++) readCheck("t6_rd_zero", 4'(a), 0);
    Reset = 1'b0;
    tick();
    dataBase = 32'hD0;
    startSweep(16'h0009);
    waitDone(n);
    check("t6_len", n, 5);
    checkOrder("t6_order", 16'h0009);
    tick();
    check("t6_cnt_after", SweepCount, 1);
    check("t6_flags_after", ChangeFlags, 16'h0009);
    readCheck("t6_rd3", 4'd3, 32'hD3);
    readCheck("t6_rd1", 4'd1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
